// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared state encoding, defaults and helpers for the life hit scheduler
package life_pkg;

  localparam int VAL_W_DEF = 10;
  localparam int MAX_LIFE  = 10;

  typedef enum logic [2:0] {
    SPAWN        = 3'd0,
    SPAWN_SETTLE = 3'd1,
    INVULN       = 3'd2,
    ALIVE        = 3'd3,
    APPLY        = 3'd4,
    HIT_SETTLE   = 3'd5,
    DEAD         = 3'd6
  } life_state_e;

  function automatic logic is_alive_state(life_state_e s);
    return (s == ALIVE) || (s == APPLY) || (s == HIT_SETTLE) || (s == INVULN);
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: first request at or after the pointer wins
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  // Scan from the farthest slot back to the pointer so the nearest requester overwrites last.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        grant_o = '0;
        grant_o[(int'(ptr_i) + k) % N] = 1'b1;
        grant_idx_o = IDX_W'((int'(ptr_i) + k) % N);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/life_hit_scheduler.sv
// rtl/life_hit_scheduler.sv - damage hit arbitration and death/respawn sequencing for the life datapath
// Optional post-spawn invulnerability window: LIFE_HIT_INVULN_EN
module life_hit_scheduler
  import life_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int VAL_W          = VAL_W_DEF,
  parameter int SETTLE_CYCLES  = 2,
  parameter int RESPAWN_CYCLES = 100,
  parameter int INVULN_CYCLES  = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       hit_req,
  input  logic [N_REQ*VAL_W-1:0] hit_value,
  output logic [N_REQ-1:0]       hit_ack,
  input  logic                   isDead,
  output logic                   isDamaged,
  output logic [VAL_W-1:0]       damagedValue,
  output logic                   isRegen,
  output logic                   alive,
  output logic [2:0]             state_dbg
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(max3(RESPAWN_CYCLES, INVULN_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'((RESPAWN_CYCLES == 0) ? 0 : RESPAWN_CYCLES - 1);
`ifdef LIFE_HIT_INVULN_EN
  localparam logic [CNT_W-1:0] INVULN_LOAD  = CNT_W'((INVULN_CYCLES == 0) ? 0 : INVULN_CYCLES - 1);
`endif

  life_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] hit_ack_q;
  logic             is_damaged_q, is_regen_q, alive_q;
  logic [VAL_W-1:0] dmg_value_q;

  logic [N_REQ-1:0] req_eff, grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any_req, take_d, apply_d, regen_d;

  // A request being acked this cycle is still held by its source; hide it so it is not granted twice.
  assign req_eff = hit_req & ~hit_ack_q;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i      (req_eff),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .grant_idx_o(grant_idx),
    .any_o      (any_req)
  );

  assign ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take_d  = 1'b0;
    apply_d = 1'b0;
    regen_d = 1'b0;
    case (state_q)
      // SPAWN spends one cycle quiet, then one cycle with the regen strobe up.
      SPAWN: begin
        if (is_regen_q) begin
          state_d = SPAWN_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          regen_d = 1'b1;
        end
      end
      SPAWN_SETTLE: begin
        if (cnt_q == '0) begin
`ifdef LIFE_HIT_INVULN_EN
          state_d = INVULN;
          cnt_d   = INVULN_LOAD;
`else
          state_d = ALIVE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef LIFE_HIT_INVULN_EN
      INVULN: begin
        take_d = any_req;
        if (cnt_q == '0) state_d = ALIVE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`endif
      ALIVE: begin
        if (isDead) begin
          state_d = DEAD;
          cnt_d   = RESPAWN_LOAD;
        end else if (any_req) begin
          take_d  = 1'b1;
          apply_d = 1'b1;
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = HIT_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      HIT_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (isDead) begin
          state_d = DEAD;
          cnt_d   = RESPAWN_LOAD;
        end else begin
          state_d = ALIVE;
        end
      end
      DEAD: begin
        take_d = any_req;
        if (cnt_q == '0) state_d = SPAWN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = SPAWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SPAWN;
      cnt_q        <= '0;
      ptr_q        <= '0;
      hit_ack_q    <= '0;
      is_damaged_q <= 1'b0;
      is_regen_q   <= 1'b0;
      alive_q      <= 1'b0;
      dmg_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hit_ack_q    <= take_d ? grant : '0;
      is_damaged_q <= apply_d;
      is_regen_q   <= regen_d;
      alive_q      <= is_alive_state(state_d);
      if (take_d)  ptr_q       <= ptr_d;
      if (apply_d) dmg_value_q <= hit_value[int'(grant_idx)*VAL_W +: VAL_W];
    end
  end

  assign hit_ack      = hit_ack_q;
  assign isDamaged    = is_damaged_q;
  assign damagedValue = dmg_value_q;
  assign isRegen      = is_regen_q;
  assign alive        = alive_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_life_hit_scheduler.sv
// tb/tb_life_hit_scheduler.sv - scoreboard bench for life_hit_scheduler with a behavioural life-point datapath
module tb_life_hit_scheduler;
  import life_pkg::*;

  localparam int N_REQ = 4;
  localparam int VAL_W = 10;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [N_REQ-1:0]       hit_req = '0;
  logic [N_REQ*VAL_W-1:0] hit_value = '0;
  logic [N_REQ-1:0]       hit_ack;
  logic                   isDead;
  logic                   isDamaged;
  logic [VAL_W-1:0]       damagedValue;
  logic                   isRegen;
  logic                   alive;
  logic [2:0]             state_dbg;

  always #10 clk = ~clk;

  life_hit_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .hit_req     (hit_req),
    .hit_value   (hit_value),
    .hit_ack     (hit_ack),
    .isDead      (isDead),
    .isDamaged   (isDamaged),
    .damagedValue(damagedValue),
    .isRegen     (isRegen),
    .alive       (alive),
    .state_dbg   (state_dbg)
  );

  // Life-point register block: edge-detected damage/regen, isDead at zero.
  int   life;
  logic dmg_prev, regen_prev;
  always @(posedge clk) begin
    if (reset) begin
      life       <= MAX_LIFE;
      dmg_prev   <= 1'b0;
      regen_prev <= 1'b0;
    end else begin
      dmg_prev   <= isDamaged;
      regen_prev <= isRegen;
      if (isRegen && !regen_prev)
        life <= MAX_LIFE;
      else if (isDamaged && !dmg_prev)
        life <= (life > int'(damagedValue)) ? life - int'(damagedValue) : 0;
    end
  end
  assign isDead = (life == 0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int src;
    int val;
    bit applied;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int src, input int val, input bit applied);
    exp_t e;
    e.src = src;
    e.val = val;
    e.applied = applied;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack pops one expectation; strobes are also checked for spacing.
  exp_t mon_e;
  logic prev_strobe;
  always @(negedge clk) begin
    if (reset) begin
      prev_strobe <= 1'b0;
    end else begin
      if (hit_ack != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", int'(hit_ack), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_onehot_src", int'(hit_ack), 1 << mon_e.src);
          check("ack_damage_strobe", int'(isDamaged), int'(mon_e.applied));
          if (mon_e.applied) check("ack_damage_value", int'(damagedValue), mon_e.val);
        end
      end
      if (isDamaged || isRegen) begin
        check("strobe_overlap", int'(isDamaged & isRegen), 0);
        check("strobe_back_to_back", int'(prev_strobe), 0);
      end
      prev_strobe <= isDamaged | isRegen;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    hit_req = hit_req & ~hit_ack;
  endtask

  task automatic wait_state(input int s, input int max, input string name);
    int n = 0;
    while (int'(state_dbg) != s && n < max) begin
      tick();
      n++;
    end
    check(name, int'(state_dbg), s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_state", int'(state_dbg), SPAWN);
    check("rst_regen", int'(isRegen), 0);
    check("rst_damaged", int'(isDamaged), 0);
    check("rst_ack", int'(hit_ack), 0);
    check("rst_alive", int'(alive), 0);
    check("rst_dmg_value", int'(damagedValue), 0);
    tick();
    reset = 1'b0;
  endtask

  // Starts in the quiet SPAWN cycle and walks to ALIVE.
  task automatic spawn_seq();
    int n;
    check("spawn_quiet", int'(isRegen), 0);
    tick();
    check("spawn_regen", int'(isRegen), 1);
    check("spawn_state", int'(state_dbg), SPAWN);
    tick();
    check("settle_state", int'(state_dbg), SPAWN_SETTLE);
    check("settle_regen", int'(isRegen), 0);
    check("settle_alive", int'(alive), 0);
    tick();
    check("settle_state2", int'(state_dbg), SPAWN_SETTLE);
    tick();
`ifdef LIFE_HIT_INVULN_EN
    n = 0;
    while (int'(state_dbg) == INVULN && n < 200) begin
      n++;
      tick();
    end
    check("invuln_len", n, 50);
`else
    n = 0;
`endif
    check("alive_state", int'(state_dbg), ALIVE);
    check("alive_flag", int'(alive), 1);
    check("life_full", life, MAX_LIFE);
  endtask

  initial begin
    int t[4];
    int k, c, n;
    int ack_state;

    // Reset then idle spawn.
    do_reset();
    spawn_seq();

    // Single hit of 3 from source 0.
    push_exp(0, 3, 1'b1);
    hit_value[9:0] = 10'd3;
    hit_req[0] = 1'b1;
    tick();
    check("hit_apply_state", int'(state_dbg), APPLY);
    check("hit_damaged", int'(isDamaged), 1);
    check("hit_ack0", int'(hit_ack), 1);
    tick();
    check("hit_damaged_low", int'(isDamaged), 0);
    check("hit_settle_state", int'(state_dbg), HIT_SETTLE);
    check("hit_life7", life, 7);
    tick();
    tick();
    check("hit_back_alive", int'(state_dbg), ALIVE);
    check("hit_still_alive", int'(alive), 1);

    // Four concurrent requesters drain life to zero.
    do_reset();
    spawn_seq();
    hit_value = {10'd4, 10'd3, 10'd2, 10'd1};
    for (int i = 0; i < 4; i++) push_exp(i, i + 1, 1'b1);
    hit_req = 4'hF;
    k = 0;
    c = 0;
    while (k < 4 && c < 40) begin
      tick();
      c++;
      if (hit_ack != '0) begin
        t[k] = c;
        k++;
      end
    end
    check("four_grants", k, 4);
    for (int i = 1; i < 4; i++) check("grant_spacing", t[i] - t[i-1], 4);
    tick();
    tick();
    check("drain_life_zero", life, 0);
    check("drain_last_settle", int'(state_dbg), HIT_SETTLE);
    tick();
    check("drain_dead", int'(state_dbg), DEAD);
    check("drain_alive_low", int'(alive), 0);

    // Requests while dead are acked and discarded; DEAD lasts the respawn delay.
    push_exp(1, 0, 1'b0);
    push_exp(2, 0, 1'b0);
    hit_req = 4'b0110;
    n = 0;
    while (int'(state_dbg) == DEAD && n < 300) begin
      n++;
      tick();
    end
    check("dead_len", n, 100);
    check("dead_discards_done", exp_q.size(), 0);
    spawn_seq();

    // Overkill hit of 15 kills from full life.
    push_exp(2, 15, 1'b1);
    hit_value[29:20] = 10'd15;
    hit_req[2] = 1'b1;
    wait_state(DEAD, 10, "death_enter");
    check("death_alive_low", int'(alive), 0);
    check("death_life_zero", life, 0);
    wait_state(SPAWN, 200, "respawn_reached");
    spawn_seq();

    // Hit shortly after spawn: discarded while invulnerable, applied otherwise.
    do_reset();
    repeat (4) tick();
`ifdef LIFE_HIT_INVULN_EN
    repeat (9) tick();
    check("invuln_cycle10", int'(state_dbg), INVULN);
    push_exp(1, 5, 1'b0);
    hit_value[19:10] = 10'd5;
    hit_req[1] = 1'b1;
    wait_state(ALIVE, 100, "invuln_to_alive");
    check("invuln_life_kept", life, MAX_LIFE);
`else
    repeat (2) tick();
    check("early_hit_alive", int'(state_dbg), ALIVE);
    push_exp(1, 5, 1'b1);
    hit_value[19:10] = 10'd5;
    hit_req[1] = 1'b1;
    tick();
    repeat (3) tick();
    check("early_hit_back_alive", int'(state_dbg), ALIVE);
    check("early_hit_life5", life, 5);
`endif
    check("early_hit_consumed", exp_q.size(), 0);

    // Reset during HIT_SETTLE with source 3 pending.
    wait_state(ALIVE, 100, "pre_reset_alive");
    push_exp(0, 1, 1'b1);
    hit_value[9:0] = 10'd1;
    hit_req[0] = 1'b1;
    wait_state(HIT_SETTLE, 10, "pre_reset_settle");
    hit_value[39:30] = 10'd2;
    hit_req[3] = 1'b1;
    tick();
    check("settle_holds_req3", int'(hit_ack), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_state", int'(state_dbg), SPAWN);
    check("midrst_damaged", int'(isDamaged), 0);
    check("midrst_regen", int'(isRegen), 0);
    check("midrst_ack", int'(hit_ack), 0);
    check("midrst_alive", int'(alive), 0);
    check("midrst_dmg_value", int'(damagedValue), 0);
`ifdef LIFE_HIT_INVULN_EN
    push_exp(3, 2, 1'b0);
`else
    push_exp(3, 2, 1'b1);
`endif
    n = 0;
    ack_state = -1;
    while (n < 200 && ack_state < 0) begin
      tick();
      n++;
      if (hit_ack[3]) ack_state = int'(state_dbg);
    end
`ifdef LIFE_HIT_INVULN_EN
    check("req3_ack_state", ack_state, INVULN);
`else
    check("req3_ack_state", ack_state, APPLY);
`endif
    wait_state(ALIVE, 100, "final_alive");

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
